// File: rtl/fitness_eval_if.sv
// Handshake and data bundle between the GA controller and the fitness evaluator.
// master drives start/pop; slave returns status flags and the fitness array.
interface fitness_eval_if;
    logic                start;
    logic signed [7:0]   pop     [16];
    logic                busy;
    logic                done;
    logic                valid;
    logic signed [26:0]  fitness [16];

    modport master (
        output start,
        output pop,
        input  busy,
        input  done,
        input  valid,
        input  fitness
    );

    modport slave (
        input  start,
        input  pop,
        output busy,
        output done,
        output valid,
        output fitness
    );
endinterface

// File: rtl/fitness_eval.sv
// Evaluates f(x) = C2*x^2 + C1*x + C0 over a latched 16-entry population, one per cycle.
// Define FITNESS_CLAMP_EN to clamp negative results to zero.
module fitness_eval #(
    parameter logic signed [7:0] C2 = -8'sd1,
    parameter logic signed [7:0] C1 = 8'sd16,
    parameter logic signed [7:0] C0 = 8'sd100
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fitness_eval_if.slave io_eval
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]          r_state;
    logic [3:0]          r_cnt;
    logic                r_done;
    logic                r_valid;
    logic signed [7:0]   r_pop [16];

    logic                r_s1_vld;
    logic [3:0]          r_s1_idx;
    logic signed [15:0]  r_sq;
    logic signed [15:0]  r_lin;

    logic signed [26:0]  r_fitness [16];

    logic                w_accept;
    logic signed [7:0]   w_x;
    logic signed [26:0]  w_sum;
    logic signed [26:0]  w_res;

    always_comb begin
        w_accept = (r_state == StIdle) && io_eval.start;
        w_x      = r_pop[r_cnt];
        w_sum    = 27'(C2) * 27'(r_sq) + 27'(r_lin) + 27'(C0);
`ifdef FITNESS_CLAMP_EN
        w_res    = w_sum[26] ? '0 : w_sum;
`else
        w_res    = w_sum;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_eval.start) begin
                        r_state <= StRun;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                    end
                end
                StRun: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) r_state <= StDrain;
                end
                StDrain: begin
                    // Stage 2 writes entry 15 on this same edge.
                    r_state <= StIdle;
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pop <= '{default: '0};
        end else if (w_accept) begin
            r_pop <= io_eval.pop;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vld <= 1'b0;
            r_s1_idx <= '0;
            r_sq     <= '0;
            r_lin    <= '0;
        end else begin
            r_s1_vld <= (r_state == StRun);
            if (r_state == StRun) begin
                r_s1_idx <= r_cnt;
                r_sq     <= 16'(w_x) * 16'(w_x);
                r_lin    <= 16'(C1) * 16'(w_x);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fitness <= '{default: '0};
        end else if (r_s1_vld) begin
            r_fitness[r_s1_idx] <= w_res;
        end
    end

    assign io_eval.busy    = (r_state != StIdle);
    assign io_eval.done    = r_done;
    assign io_eval.valid   = r_valid;
    assign io_eval.fitness = r_fitness;

endmodule

// File: tb/tb_fitness_eval.sv
// Self-checking bench for fitness_eval: table vectors, random populations vs. an arithmetic
// model, and hand-written sequences for restart-ignore, mid-run reset and held start.
module tb_fitness_eval;

    localparam int C2 = -1;
    localparam int C1 = 16;
    localparam int C0 = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fitness_eval_if bus ();

    fitness_eval dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_eval (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic signed [7:0] x;
        int                raw;
    } vec_t;

    vec_t tbl [16];

    function automatic int clamp_of(input int r);
`ifdef FITNESS_CLAMP_EN
        return (r < 0) ? 0 : r;
`else
        return r;
`endif
    endfunction

    function automatic int ref_f(input int x);
        return clamp_of(C2 * x * x + C1 * x + C0);
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic signed [7:0] p [16]);
        bus.pop   = p;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, lat, 17);
        check({tag, " busy"}, 32'(bus.busy), 0);
        check({tag, " valid"}, 32'(bus.valid), 1);
    endtask

    task automatic check_fit(input string tag, input logic signed [7:0] p [16]);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s fit[%0d]", tag, i), bus.fitness[i], ref_f(int'(p[i])));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"}, 32'(bus.busy), 0);
        check({tag, " done"}, 32'(bus.done), 0);
        check({tag, " valid"}, 32'(bus.valid), 0);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s fit[%0d]", tag, i), bus.fitness[i], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic signed [7:0] p0 [16];
        logic signed [7:0] p1 [16];
        logic              dk [40];
        logic              vk [40];
        logic              bk [40];
        int                ndone;
        int                first;
        int                found;

        tbl = '{
            '{-8'sd128, -18332}, '{8'sd127, -13997}, '{8'sd0,  100},   '{8'sd1,   115},
            '{8'sd8,    164},    '{8'sd15,  115},    '{-8'sd1, 83},    '{8'sd10,  160},
            '{8'sd20,   20},     '{8'sd30,  -320},   '{-8'sd50, -3200}, '{8'sd64, -2972},
            '{8'sd16,   100},    '{-8'sd10, -160},   '{8'sd2,  128},   '{8'sd3,   139}
        };

        bus.start = 1'b0;
        bus.pop   = '{default: '0};
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_cleared("reset");

        // Table-driven run: extremes and assorted points with hand-computed values.
        for (int i = 0; i < 16; i++) p0[i] = tbl[i].x;
        start_run(p0);
        check("tbl busy", 32'(bus.busy), 1);
        check("tbl valid low", 32'(bus.valid), 0);
        wait_done("tbl");
        for (int i = 0; i < 16; i++)
            check($sformatf("tbl fit[%0d]", i), bus.fitness[i], clamp_of(tbl[i].raw));
        tick();
        check("tbl done pulse", 32'(bus.done), 0);
        check("tbl valid hold", 32'(bus.valid), 1);

        // pop[i] = i
        for (int i = 0; i < 16; i++) p0[i] = 8'(i);
        start_run(p0);
        wait_done("ramp");
        check("ramp fit0", bus.fitness[0], 100);
        check("ramp fit8", bus.fitness[8], 164);
        check("ramp fit15", bus.fitness[15], 115);
        check_fit("ramp", p0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) p0[i] = 8'($urandom);
            start_run(p0);
            wait_done($sformatf("rand%0d", r));
            check_fit($sformatf("rand%0d", r), p0);
        end

        // start re-asserted at E5 with a different pop must be ignored.
        for (int i = 0; i < 16; i++) begin
            p0[i] = 8'($urandom);
            p1[i] = ~p0[i];
        end
        start_run(p0);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.pop   = p1;
        tick();
        bus.start = 1'b0;
        check("ign busy", 32'(bus.busy), 1);
        ndone = 0;
        first = -1;
        for (int c = 6; c <= 17; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        check("ign ndone", ndone, 1);
        check("ign done edge", first, 17);
        check_fit("ign", p0);

        // Reset sampled at E9 of a run.
        for (int i = 0; i < 16; i++) p0[i] = 8'($urandom);
        start_run(p0);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("midrst");
        for (int i = 0; i < 16; i++) p0[i] = 8'($urandom);
        start_run(p0);
        wait_done("postrst");
        check_fit("postrst", p0);

        // start held high: back-to-back runs every 18 cycles.
        for (int i = 0; i < 16; i++) p0[i] = 8'($urandom);
        bus.pop   = p0;
        bus.start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            dk[k] = bus.done;
            vk[k] = bus.valid;
            bk[k] = bus.busy;
        end
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) if (dk[k] === 1'b1) ndone++;
        check("held ndone", ndone, 2);
        check("held done17", 32'(dk[17]), 1);
        check("held done35", 32'(dk[35]), 1);
        check("held valid16", 32'(vk[16]), 0);
        check("held valid17", 32'(vk[17]), 1);
        check("held valid25", 32'(vk[25]), 0);
        check("held valid35", 32'(vk[35]), 1);
        check("held busy18", 32'(bk[18]), 1);
        found = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("held third done", found, 1);
        check_fit("held", p0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
